msg_schedule: RTL
=================

MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock, the only clock.
REQ-002 The block SHALL expose: rst_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL expose: start  input  1  one-cycle request to begin expanding a 512-bit block; sampled only in IDLE.
REQ-004 The block SHALL expose: block  input  512  message block, sampled with start; bits [511:480] = W[0] … [31:0] = W[15] (big-endian word order).
REQ-005 The block SHALL expose: w  output  32  current schedule word W[t].
REQ-006 The block SHALL expose: w_idx  output  6  index t of w, 0..63.
REQ-007 The block SHALL expose: w_valid  output  1  w/w_idx hold a valid word.
REQ-008 The block SHALL expose: w_ready  input  1  downstream accepts w when w_valid&&w_ready.
REQ-009 The block SHALL expose: busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL expose: done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-011 The block SHALL have states IDLE, LOAD (macro-enabled only), RUN, DONE.
REQ-012 The block SHALL hold a 16x32 window win[0..15], with win[i] = W[t+i] while w_idx = t.
REQ-013 IDLE with start=1 SHALL load win from block and enter RUN; w_valid SHALL rise on the next cycle with w_idx=0, w=W[0] (1-cycle latency).
REQ-014 In RUN, w SHALL equal win[0] and w_idx SHALL equal t.
REQ-015 On each accept (w_valid&&w_ready) in RUN, the window SHALL shift (win[i]<=win[i+1]), win[15] SHALL load sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], and w_idx SHALL increment.
REQ-016 Additions SHALL be modulo 2^32, with no carry out.
REQ-017 sigma0(x) SHALL be ror7^ror18^shr3; sigma1(x) SHALL be ror17^ror19^shr10.
REQ-018 Without an accept, w, w_idx and win SHALL hold unchanged; w_valid SHALL stay high (no drop under backpressure).
REQ-019 Accept at w_idx=63 SHALL enter DONE and deassert w_valid; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 start outside IDLE SHALL be ignored, with no effect on the sequence in progress.
REQ-021 start may be re-asserted on the cycle done is high; it SHALL be ignored, and the first honoured start SHALL be the one seen in IDLE.
REQ-022 In IDLE, w_valid=0; w and w_idx SHALL hold their last values.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, w=0, w_idx=0, w_valid=0, busy=0, done=0, win all zero, and in_ready=0 when present.
REQ-024 Reset mid-RUN or mid-LOAD SHALL abandon the block; after release, no output SHALL appear until a new start.

Configuration
REQ-025 Macro MSG_SCHEDULE_SERIAL_LOAD_EN SHALL select the block-load method.
REQ-026 When MSG_SCHEDULE_SERIAL_LOAD_EN is defined, the block port SHALL be removed and ports SHALL be added: in_word input 32 (block word); in_valid input 1; in_ready output 1.
REQ-027 With the macro defined, start in IDLE SHALL enter LOAD with in_ready=1.
REQ-028 In LOAD, each in_valid&&in_ready SHALL store words W[0]..W[15] in order.
REQ-029 After the 16th word, in_ready SHALL drop and the block SHALL enter RUN; w_valid SHALL be asserted the following cycle.
REQ-030 With the macro undefined, the block SHALL use the 512-bit parallel load of REQ-013, and the LOAD state, in_word, in_valid and in_ready SHALL NOT exist.

Verification
REQ-031 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000; 64 words are delivered on consecutive cycles, done asserts at the cycle after w_idx=63, and all words match the reference model.
REQ-032 All-zero block -> all 64 w = 0x00000000 and w_idx = 0..63 in order.
REQ-033 Random block, w_ready toggled pseudo-randomly -> w stable while stalled; the sequence matches the zero-stall run word for word.
REQ-034 start pulsed at w_idx=20 -> ignored; the sequence continues to 63, followed by a single done pulse.
REQ-035 rst_n asserted at w_idx=30 -> all outputs are 0 immediately; after release, w_valid stays 0 until start.
REQ-036 MSG_SCHEDULE_SERIAL_LOAD_EN defined, "abc" words fed with 3 gaps in in_valid -> in_ready drops after 16 accepts; the output matches REQ-031.

Source files
------------

// File: rtl/msg_schedule.sv
// Message-schedule expander: turns one 512-bit block into W[0..63] over a valid/ready stream.
// Optional serial word loader selected by MSG_SCHEDULE_SERIAL_LOAD_EN.
`timescale 1ns/1ps
module msg_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
    input  logic [31:0]  in_word,
    input  logic         in_valid,
    output logic         in_ready,
`else
    input  logic [511:0] block,
`endif
    output logic [31:0]  w,
    output logic [5:0]   w_idx,
    output logic         w_valid,
    input  logic         w_ready,
    output logic         busy,
    output logic         done,
    output logic [1:0]   dbg_state
);

    // Handshake: a word (or input word) transfers on a rising clk edge where valid && ready;
    // valid never drops and the offered data never changes until that transfer happens.
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, LOAD = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  w_idx_q, w_idx_d;
    logic [31:0] next_word;
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
    logic [3:0]  load_cnt_q, load_cnt_d;
`endif

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        w_idx_d   = w_idx_q;
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
        load_cnt_d = load_cnt_q;
`endif
        next_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
                    state_d    = LOAD;
                    load_cnt_d = 4'd0;
`else
                    for (int i = 0; i < 16; i++) win_d[i] = block[511 - 32*i -: 32];
                    w_idx_d = 6'd0;
                    state_d = RUN;
`endif
                end
            end
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
            LOAD: begin
                // Words shift in at the top, so after 16 of them W[0] sits in win[0].
                if (in_valid) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                    win_d[15]  = in_word;
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        w_idx_d = 6'd0;
                        state_d = RUN;
                    end
                end
            end
`endif
            RUN: begin
                if (w_ready) begin
                    // Last word: keep window and index so w/w_idx hold W[63] afterwards.
                    if (w_idx_q == 6'd63) begin
                        state_d = DONE;
                    end else begin
                        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                        win_d[15] = next_word;
                        w_idx_d   = w_idx_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_idx_q <= 6'd0;
            for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
            load_cnt_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            w_idx_q <= w_idx_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
            load_cnt_q <= load_cnt_d;
`endif
        end
    end

    assign w         = win_q[0];
    assign w_idx     = w_idx_q;
    assign w_valid   = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;
`ifdef MSG_SCHEDULE_SERIAL_LOAD_EN
    assign in_ready  = (state_q == LOAD);
`endif

endmodule
